// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit segment per stage,
// carry registered between stages, valid/ready handshake on both sides.
module add_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG;

   logic [NSEG-1:0] w_valid;
   logic [NSEG-1:0] w_free;

   // A stage can load when it is empty or its content moves on this cycle;
   // evaluated from the output side back to the input side.
   always_comb begin
      // NOTE: default every always_comb output first so no latch is inferred.
      w_free = '0;
      w_free[NSEG-1] = !w_valid[NSEG-1] || out_ready;
      for (int k = NSEG-2; k >= 0; k--) begin
         w_free[k] = !w_valid[k] || w_free[k+1];
      end
   end

   assign in_ready = w_free[0] && !rst;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int RW = WIDTH - k*SEG;   // operand bits not yet summed

      logic [RW-1:0]         w_x;
      logic [RW-1:0]         w_y;
      logic                  w_ci;
      logic                  w_vi;
      logic [SEG:0]          w_sum;
      logic [(k+1)*SEG-1:0]  w_z;
      logic                  r_valid;
      logic                  r_c;
      logic [(k+1)*SEG-1:0]  r_z;

      if (k == 0) begin : g_in
         assign w_x  = X;
         assign w_y  = sub ? ~Y : Y;
         assign w_ci = sub ? 1'b1 : cin;
         assign w_vi = in_valid;
         assign w_z  = w_sum[SEG-1:0];
      end else begin : g_in
         assign w_x  = g_stage[k-1].g_fwd.r_x;
         assign w_y  = g_stage[k-1].g_fwd.r_y;
         assign w_ci = g_stage[k-1].r_c;
         assign w_vi = g_stage[k-1].r_valid;
         assign w_z  = {w_sum[SEG-1:0], g_stage[k-1].r_z};
      end

      assign w_sum      = {1'b0, w_x[SEG-1:0]} + {1'b0, w_y[SEG-1:0]} + {{SEG{1'b0}}, w_ci};
      assign w_valid[k] = r_valid;

      always_ff @(posedge clk) begin
         if (rst) begin
            // NOTE: sequential state uses non-blocking assignment only.
            r_valid <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= '0;
         end else if (w_free[k]) begin
            r_valid <= w_vi;
            r_c     <= w_sum[SEG];
            r_z     <= w_z;
         end
      end

      if (k < NSEG-1) begin : g_fwd
         logic [RW-SEG-1:0] r_x;
         logic [RW-SEG-1:0] r_y;

         // NOTE: forwarded operands are qualified by r_valid, so they need no reset.
         always_ff @(posedge clk) begin
            if (w_free[k]) begin
               r_x <= w_x[RW-1:SEG];
               r_y <= w_y[RW-1:SEG];
            end
         end
      end else begin : g_out
         logic r_ovf;

         // Carry into the MSB is x^y^sum at that bit; overflow is that XOR carry out.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_free[k]) begin
               r_ovf <= w_x[SEG-1] ^ w_y[SEG-1] ^ w_sum[SEG-1] ^ w_sum[SEG];
            end
         end

         assign out_valid = r_valid;
         assign Z         = r_z;
         assign cout      = r_c;
         assign ovf       = r_ovf;
      end
   end

endmodule

// File: tb/tb_add_pipe.sv
// Directed and model-checked stimulus for add_pipe at 32/8, 16/8 and 8/8.
module tb_add_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
   logic [31:0] X, Y, Z;
   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_cin, h_sub, h_cout, h_ovf;
   logic [15:0] h_X, h_Y, h_Z;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cin, b_sub, b_cout, b_ovf;
   logic [7:0]  b_X, b_Y, b_Z;

   add_pipe #(.WIDTH(32), .SEG(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .Z(Z),
      .cout(cout), .ovf(ovf));

   add_pipe #(.WIDTH(16), .SEG(8)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .X(h_X), .Y(h_Y),
      .cin(h_cin), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready), .Z(h_Z),
      .cout(h_cout), .ovf(h_ovf));

   add_pipe #(.WIDTH(8), .SEG(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .X(b_X), .Y(b_Y),
      .cin(b_cin), .sub(b_sub), .out_valid(b_out_valid), .out_ready(b_out_ready), .Z(b_Z),
      .cout(b_cout), .ovf(b_ovf));

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference result {ovf, cout, Z} from a full-width sum and the sign rule.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic s);
      logic [31:0] ye;
      logic [32:0] t;
      ye = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, ye} + {32'd0, (s ? 1'b1 : c)};
      return {(x[31] == ye[31]) && (t[31] != x[31]), t[32], t[31:0]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Single transaction into an empty pipe with out_ready high: latency 4.
   task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic s, input logic [33:0] exp);
      X = x; Y = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, " rdy"}, in_ready, 1);
      tick;
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check({tag, " early"}, out_valid, 0);
         tick;
      end
      check({tag, " vld"}, out_valid, 1);
      check({tag, " res"}, {ovf, cout, Z}, exp);
      tick;
      check({tag, " drain"}, out_valid, 0);
   endtask

   logic [31:0] sx [10];
   logic [31:0] sy [10];
   logic        sc [10];
   logic        ss [10];
   logic [33:0] exp_q [$];
   int          acc, got;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0; cin = 1'b0; sub = 1'b0;
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_X = '0; h_Y = '0; h_cin = 1'b0; h_sub = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_X = '0; b_Y = '0; b_cin = 1'b0; b_sub = 1'b0;
      repeat (2) tick;
      rst = 1'b0;
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset result", {ovf, cout, Z}, 0);
      check("reset in_ready", in_ready, 1);
      check("reset h_out_valid", h_out_valid, 0);
      check("reset b_in_ready", b_in_ready, 1);

      // 16-bit: inter-segment carry, latency 2
      h_X = 16'h00FF; h_Y = 16'h0001; h_cin = 1'b0; h_sub = 1'b0; h_in_valid = 1'b1;
      tick;
      h_in_valid = 1'b0;
      check("w16 early", h_out_valid, 0);
      tick;
      check("w16 vld", h_out_valid, 1);
      check("w16 res", {h_ovf, h_cout, h_Z}, {1'b0, 1'b0, 16'h0100});

      // single-stage: latency 1, signed overflow
      b_X = 8'h7F; b_Y = 8'h01; b_cin = 1'b0; b_sub = 1'b0; b_in_valid = 1'b1;
      tick;
      b_in_valid = 1'b0;
      check("w8 vld", b_out_valid, 1);
      check("w8 res", {b_ovf, b_cout, b_Z}, {1'b1, 1'b0, 8'h80});

      // 32-bit directed vectors, expected {ovf, cout, Z} by hand
      run_one("add carry all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
      run_one("add ovf",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
      run_one("add cin",       32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A});
      run_one("sub borrow",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
      run_one("sub ovf",       32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
      run_one("sub zero",      32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0000});

      // Backpressure: fill with out_ready low, then drain with random out_ready
      for (int i = 0; i < 10; i++) begin
         sx[i] = $urandom; sy[i] = $urandom;
         sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
      end
      acc = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         X = sx[acc]; Y = sy[acc]; cin = sc[acc]; sub = ss[acc]; in_valid = 1'b1;
         #1;
         if (in_ready) begin
            exp_q.push_back(model(sx[acc], sy[acc], sc[acc], ss[acc]));
            acc++;
         end
         tick;
      end
      check("bp accepts", acc, 4);
      check("bp in_ready low", in_ready, 0);
      check("bp out_valid", out_valid, 1);
      for (int c = 0; c < 3; c++) begin
         check("bp hold", {ovf, cout, Z}, exp_q[0]);
         tick;
      end
      got = 0;
      for (int c = 0; c < 200 && got < 10; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (acc < 10);
         if (acc < 10) begin
            X = sx[acc]; Y = sy[acc]; cin = sc[acc]; sub = ss[acc];
         end
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("bp extra result", 1, 0);
            else                   check("bp res", {ovf, cout, Z}, exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(sx[acc], sy[acc], sc[acc], ss[acc]));
            acc++;
         end
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp results", got, 10);
      check("bp leftover", exp_q.size(), 0);
      check("bp no dup", out_valid, 0);
      repeat (4) tick;
      check("bp no dup late", out_valid, 0);

      // Full throughput: 100 back-to-back inputs, outputs in cycles 4..103
      for (int c = 0; c < 110; c++) begin
         if (c < 100) begin
            X = $urandom; Y = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check("tp out_valid", out_valid, (c >= 4 && c <= 103));
         if (out_valid) begin
            if (exp_q.size() == 0) check("tp extra result", 1, 0);
            else                   check("tp res", {ovf, cout, Z}, exp_q.pop_front());
         end
         if (c < 100) begin
            check("tp in_ready", in_ready, 1);
            if (in_ready) exp_q.push_back(model(X, Y, cin, sub));
         end
         tick;
      end
      check("tp leftover", exp_q.size(), 0);

      // Reset with 3 results in flight and an input presented during reset
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         X = 32'h0000_1000 + 32'(i); Y = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         tick;
      end
      in_valid = 1'b0;
      tick;
      check("rs head present", out_valid, 1);
      rst = 1'b1; in_valid = 1'b1; X = 32'hCAFE_0000; Y = 32'h0000_BEEF;
      tick;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("rs out_valid", out_valid, 0);
      check("rs result", {ovf, cout, Z}, 0);
      check("rs in_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick;
         check("rs flushed", out_valid, 0);
      end
      run_one("rs new", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, {1'b0, 1'b0, 32'h1010_1010});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
